// File: rtl/sdh_tx_pkg.sv
// sdh_tx_pkg
// Shared definitions for the SDH transmit payload feeder:
//   - IDLE_BYTE_DEFAULT : byte sent when a request finds no buffered payload
//   - LANE_MSB_FIRST    : byte-lane ordering of a payload word on the wire
//   - ser_state_e       : serialiser state (IDLE / ACTIVE)
//   - ser_t             : serialiser state register (state + byte index)
//   - lane_byte()       : picks the n-th transmitted byte out of a word
package sdh_tx_pkg;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

  // 1: bits[31:24] go out first, 0: bits[7:0] go out first.
  localparam bit LANE_MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ser_state_e;

  typedef struct packed {
    ser_state_e state;
    logic [1:0] idx;
  } ser_t;

  // idx counts transmit order (0 = first byte on the wire).
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [1:0] lane;
    lane = LANE_MSB_FIRST ? (2'd3 - idx) : idx;
    case (lane)
      2'd3:    return w[31:24];
      2'd2:    return w[23:16];
      2'd1:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sdh_tx_word_fifo.sv
// sdh_tx_word_fifo
// Generic single-clock synchronous FIFO, first-word-fall-through: rd_data
// shows the head word whenever the FIFO is non-empty, so it is valid in the
// same cycle that pop is asserted.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (discards content)
//   push, wr_data  : write request and word; ignored while full
//   pop, rd_data   : read request and head word; ignored while empty
//   full, empty    : derived from the registered level only
//   level          : words currently stored (one bit wider than pointers)
module sdh_tx_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

  // Power-of-two depth: pointers simply wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage has no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sdh_tx_payload_feeder.sv
// sdh_tx_payload_feeder
// Buffers 32-bit client payload words and serialises them MSB byte first onto
// the SDH framer's 8-bit payload input, one byte per framer request. A
// request seen in cycle N is answered on sdh_tx_din after the edge ending N.
// A request with no buffered payload returns IDLE_BYTE and bumps a
// saturating underflow counter.
// Ports:
//   sdh_clk, rst                    : clock, synchronous active-high reset
//   user_din, user_din_valid/ready  : client word input
//   sdh_tx_din_req, sdh_tx_din      : framer request and payload byte
//   fifo_level                      : words buffered
//   underflow_cnt, underflow_clr    : idle-substitution counter and its clear
//
// Client handshake: a word transfers on every sdh_clk edge where
// user_din_valid and user_din_ready are both high. user_din_ready depends
// only on registered FIFO state (and rst), never on user_din_valid; a word
// offered while ready is low is not taken and must be held by the client.
module sdh_tx_payload_feeder
  import sdh_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEFAULT
) (
  input  logic                         sdh_clk,
  input  logic                         rst,
  input  logic [31:0]                  user_din,
  input  logic                         user_din_valid,
  output logic                         user_din_ready,
  input  logic                         sdh_tx_din_req,
  output logic [7:0]                   sdh_tx_din,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  underflow_cnt,
  input  logic                         underflow_clr
);

  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_rd;
  logic        push;
  logic        pop;

  ser_t        ser_q, ser_n;
  logic [31:0] hold_q, hold_n;
  logic [7:0]  dout_q, dout_n;
  logic        uf_evt;

  assign user_din_ready = !fifo_full && !rst;
  assign push           = user_din_valid && user_din_ready;

  sdh_tx_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sdh_clk),
    .rst     (rst),
    .push    (push),
    .wr_data (user_din),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge sdh_clk) begin
    if (rst) begin
      ser_q  <= '{state: IDLE, idx: 2'd0};
      hold_q <= '0;
      dout_q <= 8'h00;
    end else begin
      ser_q  <= ser_n;
      hold_q <= hold_n;
      dout_q <= dout_n;
    end
  end

  // Pops only happen from IDLE, so an ACTIVE word is always complete and
  // can never underflow mid-word. Without a request everything holds.
  always_comb begin
    ser_n  = ser_q;
    hold_n = hold_q;
    dout_n = dout_q;
    pop    = 1'b0;
    uf_evt = 1'b0;
    if (sdh_tx_din_req) begin
      case (ser_q.state)
        IDLE: begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            hold_n      = fifo_rd;
            dout_n      = lane_byte(fifo_rd, 2'd0);
            ser_n.idx   = 2'd1;
            ser_n.state = ACTIVE;
          end else begin
            dout_n = IDLE_BYTE;
            uf_evt = 1'b1;
          end
        end
        ACTIVE: begin
          dout_n = lane_byte(hold_q, ser_q.idx);
          if (ser_q.idx == 2'd3) begin
            ser_n.idx   = 2'd0;
            ser_n.state = IDLE;
          end else begin
            ser_n.idx = ser_q.idx + 2'd1;
          end
        end
        default: begin
          ser_n.state = IDLE;
          ser_n.idx   = 2'd0;
        end
      endcase
    end
  end

  assign sdh_tx_din = dout_q;

  // Clear takes priority over a coincident underflow.
  always_ff @(posedge sdh_clk) begin
    if (rst || underflow_clr) begin
      underflow_cnt <= 16'h0000;
    end else if (uf_evt && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_sdh_tx_payload_feeder.sv
// tb_sdh_tx_payload_feeder
// Directed bench for sdh_tx_payload_feeder. Each framer request pushes the
// hand-computed byte into exp_q; the monitor branch compares sdh_tx_din one
// cycle later, and checks that the output holds when no request was made.
module tb_sdh_tx_payload_feeder;

  localparam int DEPTH = 16;

  // Clock / reset
  logic        sdh_clk = 1'b0;
  logic        rst = 1'b1;
  always #5 sdh_clk = ~sdh_clk;

  logic [31:0] user_din = '0;
  logic        user_din_valid = 1'b0;
  logic        user_din_ready;
  logic        sdh_tx_din_req = 1'b0;
  logic [7:0]  sdh_tx_din;
  logic [4:0]  fifo_level;
  logic [15:0] underflow_cnt;
  logic        underflow_clr = 1'b0;

  sdh_tx_payload_feeder #(
    .FIFO_DEPTH (DEPTH),
    .IDLE_BYTE  (8'h00)
  ) dut (
    .sdh_clk        (sdh_clk),
    .rst            (rst),
    .user_din       (user_din),
    .user_din_valid (user_din_valid),
    .user_din_ready (user_din_ready),
    .sdh_tx_din_req (sdh_tx_din_req),
    .sdh_tx_din     (sdh_tx_din),
    .fifo_level     (fifo_level),
    .underflow_cnt  (underflow_cnt),
    .underflow_clr  (underflow_clr)
  );

  // Scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change on the falling edge only.
  task automatic cyc();
    @(negedge sdh_clk);
  endtask

  task automatic do_req(input logic [7:0] e);
    sdh_tx_din_req = 1'b1;
    exp_q.push_back(e);
    cyc();
    sdh_tx_din_req = 1'b0;
  endtask

  task automatic req_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) begin
      do_req(w[8*(3-b) +: 8]);
      repeat (gap) cyc();
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    user_din       = w;
    user_din_valid = 1'b1;
    cyc();
    user_din_valid = 1'b0;
  endtask

  // Monitor: classify each edge, compare just after it.
  task automatic monitor();
    logic [1:0] ev;
    logic [7:0] last;
    logic [7:0] e;
    last = 8'h00;
    forever begin
      @(posedge sdh_clk);
      ev = rst ? 2'd2 : (sdh_tx_din_req ? 2'd1 : 2'd0);
      @(negedge sdh_clk);
      case (ev)
        2'd2: begin
          check("reset_dout", 32'(sdh_tx_din), 32'h00);
          last = 8'h00;
        end
        2'd1: begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_queue: got %0h with no expected byte at %0t", sdh_tx_din, $time);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(sdh_tx_din), 32'(e));
            last = e;
          end
        end
        default: check("hold_dout", 32'(sdh_tx_din), 32'(last));
      endcase
    end
  endtask

  task automatic run_tests();
    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ready", 32'(user_din_ready), 0);
    check("rst_cnt", 32'(underflow_cnt), 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(user_din_ready), 1);

    // Basic serialisation
    push_word(32'h11223344);
    check("t1_level_1", 32'(fifo_level), 1);
    req_word(32'h11223344, 0);
    check("t1_level_0", 32'(fifo_level), 0);

    // Gapped requests
    push_word(32'hA1A2A3A4);
    push_word(32'hB1B2B3B4);
    check("t2_level_2", 32'(fifo_level), 2);
    req_word(32'hA1A2A3A4, 2);
    req_word(32'hB1B2B3B4, 2);
    check("t2_level_0", 32'(fifo_level), 0);

    // Empty FIFO underflows, then clear coincident with an underflow
    repeat (5) do_req(8'h00);
    check("t3_cnt_5", 32'(underflow_cnt), 5);
    sdh_tx_din_req = 1'b1;
    underflow_clr  = 1'b1;
    exp_q.push_back(8'h00);
    cyc();
    sdh_tx_din_req = 1'b0;
    underflow_clr  = 1'b0;
    check("t3_clr_wins", 32'(underflow_cnt), 0);

    // Push and request together at level 0: no bypass
    user_din       = 32'h5A5B5C5D;
    user_din_valid = 1'b1;
    sdh_tx_din_req = 1'b1;
    exp_q.push_back(8'h00);
    cyc();
    user_din_valid = 1'b0;
    sdh_tx_din_req = 1'b0;
    check("t3_nobypass_cnt", 32'(underflow_cnt), 1);
    check("t3_nobypass_level", 32'(fifo_level), 1);
    req_word(32'h5A5B5C5D, 0);
    check("t3_level_0", 32'(fifo_level), 0);

    // Full FIFO
    for (int i = 0; i < DEPTH; i++) begin
      user_din       = 32'(32'h10203040 + i * 32'h01010101);
      user_din_valid = 1'b1;
      cyc();
    end
    user_din_valid = 1'b0;
    check("t4_level_full", 32'(fifo_level), DEPTH);
    check("t4_ready_low", 32'(user_din_ready), 0);
    user_din       = 32'hDEADDEAD;
    user_din_valid = 1'b1;
    sdh_tx_din_req = 1'b1;
    exp_q.push_back(8'h10);
    cyc();
    user_din_valid = 1'b0;
    sdh_tx_din_req = 1'b0;
    check("t4_level_15", 32'(fifo_level), DEPTH - 1);
    check("t4_ready_high", 32'(user_din_ready), 1);
    do_req(8'h20);
    do_req(8'h30);
    do_req(8'h40);
    check("t4_level_15_active", 32'(fifo_level), DEPTH - 1);
    user_din       = 32'h55667788;
    user_din_valid = 1'b1;
    sdh_tx_din_req = 1'b1;
    exp_q.push_back(8'h11);
    cyc();
    user_din_valid = 1'b0;
    sdh_tx_din_req = 1'b0;
    check("t4_push_pop_level", 32'(fifo_level), DEPTH - 1);

    // Reset mid-word
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t5_level_after_rst", 32'(fifo_level), 0);
    do_req(8'h00);
    check("t5_cnt_1", 32'(underflow_cnt), 1);
    push_word(32'hCAFEBABE);
    push_word(32'h99887766);
    do_req(8'hCA);
    do_req(8'hFE);
    check("t5_level_1", 32'(fifo_level), 1);
    rst = 1'b1;
    cyc();
    check("t5_rst_level", 32'(fifo_level), 0);
    check("t5_rst_ready", 32'(user_din_ready), 0);
    check("t5_rst_cnt", 32'(underflow_cnt), 0);
    rst = 1'b0;
    push_word(32'h0F1E2D3C);
    req_word(32'h0F1E2D3C, 0);
    check("t5_level_0", 32'(fifo_level), 0);

    // Saturation
    sdh_tx_din_req = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      exp_q.push_back(8'h00);
      cyc();
    end
    sdh_tx_din_req = 1'b0;
    check("t6_cnt_sat", 32'(underflow_cnt), 32'hFFFF);
    underflow_clr = 1'b1;
    cyc();
    underflow_clr = 1'b0;
    check("t6_cnt_clr", 32'(underflow_cnt), 0);

    cyc();
    cyc();
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        repeat (90000) @(posedge sdh_clk);
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
